dual_port_ram: RTL and testbench
================================

DUAL_PORT_RAM -- requirements
Module: dual_port_ram

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32: word width in bits; SHALL be a multiple of 8.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8: address width; depth DEPTH = 2**ADDR_WIDTH words.
REQ-003 The block SHALL have parameter READ_MODE, default 0: same-address collision policy; 0 = read-first (old data), 1 = write-first (new data).
REQ-004 The block SHALL have parameter OUT_REG, default 0: 1 adds one output register stage.
REQ-005 The block SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-006 The block SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 The block SHALL have port clr, input, 1: request a memory clear sweep.
REQ-008 The block SHALL have port busy, output, 1: clear sweep in progress; both ports blocked.
REQ-009 The block SHALL have port wr_en, input, 1: write request.
REQ-010 The block SHALL have port wr_addr, input, ADDR_WIDTH: write address.
REQ-011 The block SHALL have port wr_data, input, DATA_WIDTH: write data.
REQ-012 The block SHALL have port wr_be, input, DATA_WIDTH/8: byte enables; bit i covers wr_data[8i+7:8i].
REQ-013 The block SHALL have port rd_en, input, 1: read request.
REQ-014 The block SHALL have port rd_addr, input, ADDR_WIDTH: read address.
REQ-015 The block SHALL have port rd_data, output, DATA_WIDTH: read data.
REQ-016 The block SHALL have port rd_valid, output, 1: rd_data carries a new read result this cycle.

Function
REQ-017 The controller SHALL have two states: SWEEP (busy=1) and READY (busy=0).
REQ-018 In SWEEP, each cycle SHALL write all-zero to ram[cnt] and increment cnt; on the cycle cnt==DEPTH-1 it SHALL write that word and move to READY; the sweep SHALL take exactly DEPTH cycles.
REQ-019 clr sampled high in READY SHALL enter SWEEP next cycle with cnt=0; clr during SWEEP SHALL be ignored (no restart).
REQ-020 While busy=1, wr_en and rd_en SHALL be ignored: no array write from the port, no read issued, rd_valid=0.
REQ-021 Write (READY, wr_en=1): for each i with wr_be[i]=1, byte i of ram[wr_addr] SHALL take byte i of wr_data at the clock edge; bytes with wr_be[i]=0 SHALL be unchanged; wr_be all-zero SHALL be a no-op.
REQ-022 Read (READY, rd_en=1): rd_data SHALL show ram[rd_addr] with latency L = 1 + OUT_REG cycles; rd_valid SHALL pulse high for one cycle in the same cycle as that data.
REQ-023 Back-to-back reads SHALL be accepted every cycle with throughput one per cycle and order preserved.
REQ-024 rd_data SHALL hold its last value when no new result is delivered.
REQ-025 Collision (rd_en, wr_en, rd_addr==wr_addr, same cycle): READ_MODE=0 SHALL return the pre-write word; READ_MODE=1 SHALL return the merged word (enabled bytes from wr_data, others old).
REQ-026 Reads issued in the cycle before busy rises SHALL still complete with rd_valid after L cycles.
REQ-027 Addresses SHALL cover 0..DEPTH-1 fully, with no wrap logic beyond natural ADDR_WIDTH truncation.

Reset
REQ-028 On rst_n=0, asynchronously: state=SWEEP, cnt=0, busy=1, rd_valid=0, rd_data=0, all read-pipeline valid bits=0.
REQ-029 The array has no asynchronous reset; after rst_n rises, the sweep SHALL zero it in DEPTH cycles before READY.
REQ-030 Reset asserted mid-sweep or mid-read SHALL abort the operation, drop in-flight rd_valid, and restart the sweep from cnt=0.

Verification (DATA_WIDTH=32, ADDR_WIDTH=4)
REQ-031 Release reset -> busy high exactly 16 cycles, then 0; reads of addresses 0..15 return 0x00000000.
REQ-032 Write 0xDEADBEEF to address 3 with be=1111, then with be=0010 write 0x0000AA00 -> read address 3 returns 0xDEADAAEF; L=1 (OUT_REG=0) and L=2 (OUT_REG=1) both checked via rd_valid timing.
REQ-033 Address 5 holds 0x11111111; same cycle write 0x22222222 (be=1111) and read address 5 -> READ_MODE=0 returns 0x11111111, READ_MODE=1 returns 0x22222222.
REQ-034 Reads of 0..15 on consecutive cycles -> 16 consecutive rd_valid pulses with data in order.
REQ-035 Pulse clr in READY with address 7 = 0x12345678 -> busy for 16 cycles, port writes ignored during it, read address 7 returns 0; clr pulse mid-sweep does not extend busy.
REQ-036 Assert rst_n=0 with a read in flight -> rd_valid=0 and rd_data=0 immediately; after release, a full 16-cycle sweep follows.

Source files
------------

// File: rtl/dual_port_ram.sv
// rtl/dual_port_ram.sv - byte-enabled simple dual-port RAM with power-up/clr zero sweep
// and an optional output register on the read path.
module dual_port_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int READ_MODE  = 0,
  parameter int OUT_REG    = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  output logic                    busy,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid
);

  localparam int DEPTH  = 2**ADDR_WIDTH;
  localparam int NBYTES = DATA_WIDTH/8;

  typedef enum logic {ST_SWEEP, ST_READY} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [ADDR_WIDTH-1:0] w_cnt_nxt;
  logic                  w_busy;
  logic                  w_wr_fire;
  logic                  w_rd_fire;
  logic                  w_collide;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic [DATA_WIDTH-1:0] w_rd_result;

  logic                  r_rd_v1;
  logic [DATA_WIDTH-1:0] r_rd_d1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_SWEEP;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // clr is only honoured in READY, so a pulse mid-sweep cannot extend busy.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_busy      = 1'b0;
    case (r_state)
      ST_SWEEP: begin
        w_busy    = 1'b1;
        w_cnt_nxt = r_cnt + ADDR_WIDTH'(1);
        if (r_cnt == {ADDR_WIDTH{1'b1}}) begin
          w_state_nxt = ST_READY;
        end
      end
      ST_READY: begin
        if (clr) begin
          w_state_nxt = ST_SWEEP;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_SWEEP;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign busy      = w_busy;
  assign w_wr_fire = wr_en & ~w_busy;
  assign w_rd_fire = rd_en & ~w_busy;
  assign w_collide = w_wr_fire & (wr_addr == rd_addr);

  // Storage array has no reset; the sweep owns the write port while busy.
  always_ff @(posedge clk) begin
    if (w_busy) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr_fire) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (wr_be[i]) begin
          r_mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  assign w_rd_word = r_mem[rd_addr];

  // Write-first forwards the enabled bytes of the colliding write.
  always_comb begin
    w_rd_result = w_rd_word;
    if ((READ_MODE == 1) && w_collide) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (wr_be[i]) begin
          w_rd_result[8*i +: 8] = wr_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_v1 <= 1'b0;
      r_rd_d1 <= '0;
    end else begin
      r_rd_v1 <= w_rd_fire;
      if (w_rd_fire) begin
        r_rd_d1 <= w_rd_result;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                  r_rd_v2;
      logic [DATA_WIDTH-1:0] r_rd_d2;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_rd_v2 <= 1'b0;
          r_rd_d2 <= '0;
        end else begin
          r_rd_v2 <= r_rd_v1;
          if (r_rd_v1) begin
            r_rd_d2 <= r_rd_d1;
          end
        end
      end

      assign rd_valid = r_rd_v2;
      assign rd_data  = r_rd_d2;
    end else begin : g_no_out_reg
      assign rd_valid = r_rd_v1;
      assign rd_data  = r_rd_d1;
    end
  endgenerate

endmodule

// File: tb/tb_dual_port_ram.sv
// tb/tb_dual_port_ram.sv - bench for dual_port_ram: read-first/L=1 and write-first/L=2
// instances share stimulus and are compared against an array-based reference model.
module tb_dual_port_ram;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        rd_en;
  logic [3:0]  rd_addr;

  logic        busy0, busy1;
  logic        v0, v1;
  logic [31:0] d0, d1;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_mem [16];
  int          m_left;
  logic        iss_v, iss_v_p;
  logic [31:0] iss_d0, iss_d1, iss_d1_p;
  logic [31:0] held0, held1;

  dual_port_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_MODE(0), .OUT_REG(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(d0), .rd_valid(v0)
  );

  dual_port_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .READ_MODE(1), .OUT_REG(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(d1), .rd_valid(v1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = data[8*i +: 8];
    return r;
  endfunction

  task automatic check_outputs();
    check("busy0", {31'b0, busy0}, {31'b0, m_left != 0});
    check("busy1", {31'b0, busy1}, {31'b0, m_left != 0});
    check("valid_l1", {31'b0, v0}, {31'b0, iss_v});
    check("valid_l2", {31'b0, v1}, {31'b0, iss_v_p});
    check("data_rf", d0, held0);
    check("data_wf", d1, held1);
  endtask

  // One clock: update the model from the current inputs, then compare after the edge.
  task automatic tick();
    logic ready;
    logic [31:0] old;
    ready    = (m_left == 0);
    iss_v_p  = iss_v;
    iss_d1_p = iss_d1;
    iss_v    = ready && rd_en;
    if (iss_v) begin
      old    = m_mem[rd_addr];
      iss_d0 = old;
      iss_d1 = (wr_en && wr_addr == rd_addr) ? merge(old, wr_data, wr_be) : old;
    end
    if (!ready) begin
      m_mem[16 - m_left] = 32'h0;
      m_left--;
    end else begin
      if (wr_en) m_mem[wr_addr] = merge(m_mem[wr_addr], wr_data, wr_be);
      if (clr) m_left = 16;
    end
    if (iss_v)   held0 = iss_d0;
    if (iss_v_p) held1 = iss_d1_p;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle();
    clr = 0; wr_en = 0; rd_en = 0; wr_be = 4'h0;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1; wr_addr = a; wr_data = d; wr_be = be;
    tick();
    idle();
  endtask

  task automatic do_read(input logic [3:0] a);
    rd_en = 1; rd_addr = a;
    tick();
    idle();
  endtask

  task automatic count_busy(input string tag);
    int n;
    n = 0;
    while (busy0 && n < 100) begin
      tick();
      n++;
    end
    check(tag, n, 16);
  endtask

  task automatic model_reset();
    iss_v = 0; iss_v_p = 0; held0 = '0; held1 = '0; m_left = 16;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_mem[i] = $urandom;
    iss_d0 = '0; iss_d1 = '0; iss_d1_p = '0;
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    idle();
    rst_n = 0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy0 & busy1}, 32'd1);
    check_outputs();
    rst_n = 1;
    count_busy("sweep_len_por");

    for (int i = 0; i < 16; i++) begin
      rd_en = 1; rd_addr = 4'(i);
      tick();
    end
    idle();
    tick(); tick();

    do_write(4'd3, 32'hDEADBEEF, 4'b1111);
    do_write(4'd3, 32'h0000AA00, 4'b0010);
    do_read(4'd3);
    tick(); tick();
    check("merge_rf", d0, 32'hDEADAAEF);
    check("merge_wf", d1, 32'hDEADAAEF);

    do_write(4'd5, 32'h11111111, 4'b1111);
    wr_en = 1; wr_addr = 4'd5; wr_data = 32'h22222222; wr_be = 4'b1111;
    rd_en = 1; rd_addr = 4'd5;
    tick();
    idle();
    tick(); tick();
    check("collide_rf", d0, 32'h11111111);
    check("collide_wf", d1, 32'h22222222);

    for (int c = 0; c < 300; c++) begin
      clr     = ($urandom_range(0, 39) == 0);
      wr_en   = $urandom_range(0, 1);
      wr_addr = 4'($urandom_range(0, 15));
      wr_data = $urandom;
      wr_be   = 4'($urandom_range(0, 15));
      rd_en   = $urandom_range(0, 1);
      rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
      tick();
    end
    idle();
    while (busy0 && m_left > 0) tick();
    tick(); tick();

    do_write(4'd7, 32'h12345678, 4'b1111);
    clr = 1;
    tick();
    clr = 0;
    begin
      int n;
      n = 0;
      while (busy0 && n < 100) begin
        wr_en = 1; wr_addr = 4'd7; wr_data = $urandom; wr_be = 4'hF;
        clr = (n == 8);
        tick();
        n++;
      end
      idle();
      check("sweep_len_clr", n, 16);
    end
    do_read(4'd7);
    tick(); tick();
    check("clr_addr7_rf", d0, 32'h0);
    check("clr_addr7_wf", d1, 32'h0);

    do_write(4'd9, 32'hCAFEF00D, 4'b1111);
    rd_en = 1; rd_addr = 4'd9;
    tick();
    idle();
    rst_n = 0;
    #1;
    model_reset();
    check("rst_async_v0", {31'b0, v0}, 32'd0);
    check("rst_async_v1", {31'b0, v1}, 32'd0);
    check("rst_async_d0", d0, 32'h0);
    check("rst_async_d1", d1, 32'h0);
    check("rst_async_busy", {31'b0, busy0}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    count_busy("sweep_len_rst");
    do_read(4'd9);
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
